instr_decode_stage: RTL

Registered instruction decode stage for the nRisc core. It sits between instruction memory and the register file/ALU. It slices each fetched instruction word into operation, register indices and immediate. Compared with the single-word splitter it supersedes, it adds:
- parameterised field widths
- selectable sign/zero immediate extension
- optional two-word "long immediate" li form
- valid/ready handshakes on both sides
- a decode toggle that flips once per issued instruction

---
 rtl/nrisc_pkg.sv | 33 +++
 rtl/instr_field_slicer.sv | 69 ++++++
 rtl/instr_decode_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// ============================================================================
// Module  : nrisc_pkg
// Brief   : Shared widths, opcodes and decode-state encoding for nRisc.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package nrisc_pkg;

    localparam int C_INSTR_W = 8;
    localparam int C_OP_W    = 3;
    localparam int C_RA_W    = 3;
    localparam int C_RB_W    = 2;
    localparam int C_REG_W   = 3;
    localparam int C_DATA_W  = 8;

    localparam logic [C_OP_W-1:0] C_OP_ADD = 3'b000;
    localparam logic [C_OP_W-1:0] C_OP_SUB = 3'b001;
    localparam logic [C_OP_W-1:0] C_OP_AND = 3'b010;
    localparam logic [C_OP_W-1:0] C_OP_OR  = 3'b011;
    localparam logic [C_OP_W-1:0] C_OP_LD  = 3'b100;
    localparam logic [C_OP_W-1:0] C_OP_ST  = 3'b101;
    localparam logic [C_OP_W-1:0] C_OP_BR  = 3'b110;
    localparam logic [C_OP_W-1:0] C_OP_LI  = 3'b111;

    typedef enum logic [0:0] {
        S_HEAD = 1'b0,
        S_IMM  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_field_slicer.sv
// ============================================================================
// Module  : instr_field_slicer
// Brief   : Splits an instruction word into op/ra/rb and immediates.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_slicer
    import nrisc_pkg::*;
#(
    parameter int INSTR_W  = C_INSTR_W,
    parameter int OP_W     = C_OP_W,
    parameter int RA_W     = C_RA_W,
    parameter int RB_W     = C_RB_W,
    parameter int REG_W    = C_REG_W,
    parameter int DATA_W   = C_DATA_W,
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [OP_W-1:0]    o_op,
    output logic [REG_W-1:0]   o_ra,
    output logic [REG_W-1:0]   o_rb,
    output logic [DATA_W-1:0]  o_imm_short,
    output logic [DATA_W-1:0]  o_imm_word
);

    localparam int IMM_W = INSTR_W - OP_W;

    logic [RA_W-1:0]  w_ra;
    logic [RB_W-1:0]  w_rb;
    logic [IMM_W-1:0] w_imm;
    logic             w_fill;

    assign o_op   = i_instr[INSTR_W-1 -: OP_W];
    assign w_ra   = i_instr[IMM_W-1 -: RA_W];
    assign w_rb   = i_instr[IMM_W-RA_W-1 -: RB_W];
    assign w_imm  = i_instr[IMM_W-1:0];
    assign w_fill = SIGN_EXT & w_imm[IMM_W-1];

    generate
        if (REG_W > RA_W) begin : g_ra_pad
            assign o_ra = {{(REG_W-RA_W){1'b0}}, w_ra};
        end else begin : g_ra_fit
            assign o_ra = w_ra;
        end

        if (REG_W > RB_W) begin : g_rb_pad
            assign o_rb = {{(REG_W-RB_W){1'b0}}, w_rb};
        end else begin : g_rb_fit
            assign o_rb = w_rb;
        end

        // Short immediate sign/zero-extends; the li second word only ever zero-extends.
        if (DATA_W > IMM_W) begin : g_imm_pad
            assign o_imm_short = {{(DATA_W-IMM_W){w_fill}}, w_imm};
        end else begin : g_imm_trunc
            assign o_imm_short = w_imm[DATA_W-1:0];
        end

        if (DATA_W > INSTR_W) begin : g_word_pad
            assign o_imm_word = {{(DATA_W-INSTR_W){1'b0}}, i_instr};
        end else begin : g_word_trunc
            assign o_imm_word = i_instr[DATA_W-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
// ============================================================================
// Module  : instr_decode_stage
// Brief   : Registered nRisc decode stage with li long-immediate form.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode_stage
    import nrisc_pkg::*;
#(
    parameter int              INSTR_W   = C_INSTR_W,
    parameter int              OP_W      = C_OP_W,
    parameter int              RA_W      = C_RA_W,
    parameter int              RB_W      = C_RB_W,
    parameter int              REG_W     = C_REG_W,
    parameter int              DATA_W    = C_DATA_W,
    parameter logic [OP_W-1:0] LI_OPCODE = C_OP_LI,
    parameter bit              EXT_IMM   = 1'b1,
    parameter bit              SIGN_EXT  = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_operation,
    output logic [REG_W-1:0]   out_reg_a,
    output logic [REG_W-1:0]   out_reg_b,
    output logic [DATA_W-1:0]  out_imm,
    output logic               out_long,
    output logic               out_signal
);

    logic [OP_W-1:0]   w_op;
    logic [REG_W-1:0]  w_ra;
    logic [REG_W-1:0]  w_rb;
    logic [DATA_W-1:0] w_imm_short;
    logic [DATA_W-1:0] w_imm_word;
    logic              w_in_ready;
    logic              w_accept;

    state_t            r_state;
    logic [OP_W-1:0]   r_hold_op;
    logic [REG_W-1:0]  r_hold_ra;
    logic [REG_W-1:0]  r_hold_rb;
    logic              r_out_valid;
    logic [OP_W-1:0]   r_out_op;
    logic [REG_W-1:0]  r_out_ra;
    logic [REG_W-1:0]  r_out_rb;
    logic [DATA_W-1:0] r_out_imm;
    logic              r_out_long;
    logic              r_out_signal;

    instr_field_slicer #(
        .INSTR_W  (INSTR_W),
        .OP_W     (OP_W),
        .RA_W     (RA_W),
        .RB_W     (RB_W),
        .REG_W    (REG_W),
        .DATA_W   (DATA_W),
        .SIGN_EXT (SIGN_EXT)
    ) u_slicer (
        .i_instr     (in_instr),
        .o_op        (w_op),
        .o_ra        (w_ra),
        .o_rb        (w_rb),
        .o_imm_short (w_imm_short),
        .o_imm_word  (w_imm_word)
    );

    // The output register frees up in the same cycle it drains, so streaming has no bubble.
    assign w_in_ready = !reset && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_HEAD;
            r_hold_op    <= '0;
            r_hold_ra    <= '0;
            r_hold_rb    <= '0;
            r_out_valid  <= 1'b0;
            r_out_op     <= '0;
            r_out_ra     <= '0;
            r_out_rb     <= '0;
            r_out_imm    <= '0;
            r_out_long   <= 1'b0;
            r_out_signal <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    S_HEAD: begin
                        if (EXT_IMM && (w_op == LI_OPCODE)) begin
                            r_hold_op <= w_op;
                            r_hold_ra <= w_ra;
                            r_hold_rb <= w_rb;
                            r_state   <= S_IMM;
                        end else begin
                            r_out_valid  <= 1'b1;
                            r_out_op     <= w_op;
                            r_out_ra     <= w_ra;
                            r_out_rb     <= w_rb;
                            r_out_imm    <= w_imm_short;
                            r_out_long   <= 1'b0;
                            r_out_signal <= ~r_out_signal;
                        end
                    end
                    S_IMM: begin
                        r_out_valid  <= 1'b1;
                        r_out_op     <= r_hold_op;
                        r_out_ra     <= r_hold_ra;
                        r_out_rb     <= r_hold_rb;
                        r_out_imm    <= w_imm_word;
                        r_out_long   <= 1'b1;
                        r_out_signal <= ~r_out_signal;
                        r_state      <= S_HEAD;
                    end
                    default: r_state <= S_HEAD;
                endcase
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign out_operation = r_out_op;
    assign out_reg_a     = r_out_ra;
    assign out_reg_b     = r_out_rb;
    assign out_imm       = r_out_imm;
    assign out_long      = r_out_long;
    assign out_signal    = r_out_signal;

endmodule

`default_nettype wire
